// File: rtl/pipe_stage_reg_if.sv
// Handshake and payload bundle for one pipeline stage register.
// The master drives upstream beats and downstream ready; the slave is the stage.
interface pipe_stage_reg_if #(
  parameter int KEEP_W = 32,
  parameter int KILL_W = 74,
  parameter int EXP_W  = 3,
  parameter int N_EXP  = 2
);
  logic              flush;
  logic              in_valid;
  logic              in_ready;
  logic [KEEP_W-1:0] in_keep;
  logic [KILL_W-1:0] in_kill;
  logic [EXP_W-1:0]  in_exp_code;
  logic [N_EXP-1:0]  exp_req;
  logic              out_valid;
  logic              out_ready;
  logic [KEEP_W-1:0] out_keep;
  logic [KILL_W-1:0] out_kill;
  logic [EXP_W-1:0]  out_exp_code;
  logic [1:0]        occupancy;

  modport master (
    output flush, in_valid, in_keep, in_kill, in_exp_code, exp_req, out_ready,
    input  in_ready, out_valid, out_keep, out_kill, out_exp_code, occupancy
  );

  modport slave (
    input  flush, in_valid, in_keep, in_kill, in_exp_code, exp_req, out_ready,
    output in_ready, out_valid, out_keep, out_kill, out_exp_code, occupancy
  );
endinterface

// File: rtl/pipe_stage_reg.sv
// Two-entry skid pipeline register with exception capture and flush.
// Main entry drives the outputs; skid absorbs one beat while main is stalled.
module pipe_stage_reg #(
  parameter int                KEEP_W   = 32,
  parameter int                KILL_W   = 74,
  parameter logic [KILL_W-1:0] KILL_NOP = {KILL_W{1'b0}},
  parameter int                EXP_W    = 3,
  parameter int                N_EXP    = 2
) (
  input logic             clk,
  input logic             reset,
  pipe_stage_reg_if.slave bus
);

  logic              main_valid_q, main_valid_d;
  logic [KEEP_W-1:0] main_keep_q,  main_keep_d;
  logic [KILL_W-1:0] main_kill_q,  main_kill_d;
  logic [EXP_W-1:0]  main_code_q,  main_code_d;
  logic              skid_valid_q, skid_valid_d;
  logic [KEEP_W-1:0] skid_keep_q,  skid_keep_d;
  logic [KILL_W-1:0] skid_kill_q,  skid_kill_d;
  logic [EXP_W-1:0]  skid_code_q,  skid_code_d;
  logic              in_ready_q,   in_ready_d;

  logic              accept;
  logic              xfer;
  logic [KILL_W-1:0] inc_kill;
  logic [EXP_W-1:0]  inc_code;

  assign accept = bus.in_valid & in_ready_q;
  assign xfer   = main_valid_q & bus.out_ready;

  // Descending scan so the lowest set request is the one left standing.
  always_comb begin
    inc_kill = bus.in_kill;
    inc_code = bus.in_exp_code;
    for (int i = N_EXP - 1; i >= 0; i--) begin
      if (bus.exp_req[i]) begin
        inc_kill = KILL_NOP;
        inc_code = EXP_W'(i + 1);
      end
    end
  end

  always_comb begin
    main_valid_d = main_valid_q;
    main_keep_d  = main_keep_q;
    main_kill_d  = main_kill_q;
    main_code_d  = main_code_q;
    skid_valid_d = skid_valid_q;
    skid_keep_d  = skid_keep_q;
    skid_kill_d  = skid_kill_q;
    skid_code_d  = skid_code_q;

    if (bus.flush) begin
      main_valid_d = 1'b0;
      main_keep_d  = '0;
      main_kill_d  = KILL_NOP;
      main_code_d  = '0;
      skid_valid_d = 1'b0;
      skid_keep_d  = '0;
      skid_kill_d  = KILL_NOP;
      skid_code_d  = '0;
    end else if (!main_valid_q || xfer) begin
      // Skid is always older than anything arriving now, so it refills main first.
      if (skid_valid_q) begin
        main_valid_d = 1'b1;
        main_keep_d  = skid_keep_q;
        main_kill_d  = skid_kill_q;
        main_code_d  = skid_code_q;
        skid_valid_d = 1'b0;
      end else if (accept) begin
        main_valid_d = 1'b1;
        main_keep_d  = bus.in_keep;
        main_kill_d  = inc_kill;
        main_code_d  = inc_code;
      end else begin
        main_valid_d = 1'b0;
      end
    end else if (accept) begin
      skid_valid_d = 1'b1;
      skid_keep_d  = bus.in_keep;
      skid_kill_d  = inc_kill;
      skid_code_d  = inc_code;
    end

    in_ready_d = !skid_valid_d;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      main_valid_q <= 1'b0;
      main_keep_q  <= '0;
      main_kill_q  <= KILL_NOP;
      main_code_q  <= '0;
      skid_valid_q <= 1'b0;
      skid_keep_q  <= '0;
      skid_kill_q  <= KILL_NOP;
      skid_code_q  <= '0;
      in_ready_q   <= 1'b1;
    end else begin
      main_valid_q <= main_valid_d;
      main_keep_q  <= main_keep_d;
      main_kill_q  <= main_kill_d;
      main_code_q  <= main_code_d;
      skid_valid_q <= skid_valid_d;
      skid_keep_q  <= skid_keep_d;
      skid_kill_q  <= skid_kill_d;
      skid_code_q  <= skid_code_d;
      in_ready_q   <= in_ready_d;
    end
  end

  assign bus.in_ready     = in_ready_q;
  assign bus.out_valid    = main_valid_q;
  assign bus.out_keep     = main_keep_q;
  assign bus.out_kill     = main_kill_q;
  assign bus.out_exp_code = main_code_q;
  assign bus.occupancy    = 2'(main_valid_q) + 2'(skid_valid_q);

endmodule

// File: tb/tb_pipe_stage_reg.sv
// Scoreboard bench for pipe_stage_reg: directed scenarios then random traffic.
// The model is an ordered queue of expected beats; its length is the occupancy.
module tb_pipe_stage_reg;
  localparam int                KEEP_W   = 32;
  localparam int                KILL_W   = 74;
  localparam int                EXP_W    = 3;
  localparam int                N_EXP    = 2;
  localparam logic [KILL_W-1:0] KILL_NOP = '0;

  typedef struct packed {
    logic [KEEP_W-1:0] keep;
    logic [KILL_W-1:0] kill;
    logic [EXP_W-1:0]  code;
  } beat_t;

  logic clk   = 1'b0;
  logic reset = 1'b0;
  always #5 clk = ~clk;

  pipe_stage_reg_if #(.KEEP_W(KEEP_W), .KILL_W(KILL_W), .EXP_W(EXP_W), .N_EXP(N_EXP)) bus ();

  pipe_stage_reg #(
    .KEEP_W(KEEP_W), .KILL_W(KILL_W), .KILL_NOP(KILL_NOP), .EXP_W(EXP_W), .N_EXP(N_EXP)
  ) dut (
    .clk  (clk),
    .reset(reset),
    .bus  (bus)
  );

  beat_t exp_q[$];
  int    checks   = 0;
  int    failures = 0;
  bit    expect_cleared = 1'b0;

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h t=%0t", name, act, req, $time);
    end
  endtask

  // Lowest-numbered request wins and replaces side effects with a bubble.
  function automatic beat_t model(input logic [KEEP_W-1:0] k, input logic [KILL_W-1:0] kl,
                                  input logic [EXP_W-1:0] c, input logic [N_EXP-1:0] r);
    beat_t b;
    b.keep = k;
    b.kill = kl;
    b.code = c;
    for (int i = 0; i < N_EXP; i++) begin
      if (r[i]) begin
        b.kill = KILL_NOP;
        b.code = EXP_W'(i + 1);
        break;
      end
    end
    return b;
  endfunction

  // Monitor: compare current state with the model, then apply this cycle's handshakes.
  always @(negedge clk) begin
    if (!reset) begin
      exp_q.delete();
      expect_cleared = 1'b0;
    end else begin
      chk("occupancy", 128'(bus.occupancy), 128'(exp_q.size()));
      chk("out_valid", 128'(bus.out_valid), 128'(exp_q.size() != 0));
      chk("in_ready",  128'(bus.in_ready),  128'(exp_q.size() < 2));
      if (bus.out_valid && exp_q.size() > 0) begin
        chk("out_keep", 128'(bus.out_keep),     128'(exp_q[0].keep));
        chk("out_kill", 128'(bus.out_kill),     128'(exp_q[0].kill));
        chk("out_code", 128'(bus.out_exp_code), 128'(exp_q[0].code));
      end
      if (expect_cleared) begin
        chk("flush_keep", 128'(bus.out_keep),     128'(0));
        chk("flush_kill", 128'(bus.out_kill),     128'(KILL_NOP));
        chk("flush_code", 128'(bus.out_exp_code), 128'(0));
        expect_cleared = 1'b0;
      end
      if (bus.flush) begin
        exp_q.delete();
        expect_cleared = 1'b1;
      end else begin
        if (bus.out_valid && bus.out_ready && exp_q.size() > 0) void'(exp_q.pop_front());
        if (bus.in_valid && bus.in_ready)
          exp_q.push_back(model(bus.in_keep, bus.in_kill, bus.in_exp_code, bus.exp_req));
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic set_beat(input logic [KEEP_W-1:0] k, input logic [KILL_W-1:0] kl,
                          input logic [EXP_W-1:0] c, input logic [N_EXP-1:0] r);
    bus.in_valid    = 1'b1;
    bus.in_keep     = k;
    bus.in_kill     = kl;
    bus.in_exp_code = c;
    bus.exp_req     = r;
  endtask

  // Hold a beat until the stage takes it, with a bounded wait.
  task automatic offer(input logic [KEEP_W-1:0] k, input logic [KILL_W-1:0] kl,
                       input logic [EXP_W-1:0] c, input logic [N_EXP-1:0] r);
    logic acc;
    set_beat(k, kl, c, r);
    for (int n = 0; n < 20; n++) begin
      @(negedge clk);
      acc = bus.in_ready;
      step();
      if (acc) begin
        bus.in_valid = 1'b0;
        bus.exp_req  = '0;
        return;
      end
    end
    chk("accept_timeout", 128'(0), 128'(1));
    bus.in_valid = 1'b0;
  endtask

  task automatic idle(input int n);
    bus.in_valid = 1'b0;
    bus.exp_req  = '0;
    for (int i = 0; i < n; i++) step();
  endtask

  initial begin
    bus.flush       = 1'b0;
    bus.in_valid    = 1'b0;
    bus.in_keep     = '0;
    bus.in_kill     = '0;
    bus.in_exp_code = '0;
    bus.exp_req     = '0;
    bus.out_ready   = 1'b0;
    #23;
    reset = 1'b1;
    step();
    idle(1);

    // Back-to-back stream with free downstream.
    bus.out_ready = 1'b1;
    for (int k = 0; k < 3; k++) begin
      set_beat(KEEP_W'(32'h100 + 4 * k), KILL_W'(k + 7), EXP_W'(0), '0);
      step();
    end
    idle(4);

    // Stall: A in main, B in skid, C held off, then everything drains in order.
    bus.out_ready = 1'b0;
    offer(32'hA, KILL_W'(1), 3'd0, 2'b00);
    offer(32'hB, KILL_W'(2), 3'd0, 2'b00);
    set_beat(32'hC, KILL_W'(3), 3'd0, 2'b00);
    step();
    step();
    bus.out_ready = 1'b1;
    offer(32'hC, KILL_W'(3), 3'd0, 2'b00);
    idle(4);

    // Exception capture and priority.
    offer(32'h1234, {KILL_W{1'b1}}, 3'd0, 2'b11);
    offer(32'h5678, {KILL_W{1'b1}}, 3'd0, 2'b10);
    offer(32'h9abc, {KILL_W{1'b1}}, 3'd5, 2'b00);
    offer(32'hdef0, {KILL_W{1'b1}}, 3'd6, 2'b01);
    idle(3);

    // Flush while full with a competing beat and ready downstream.
    bus.out_ready = 1'b0;
    offer(32'h11, KILL_W'(11), 3'd0, 2'b00);
    offer(32'h22, KILL_W'(22), 3'd0, 2'b00);
    set_beat(32'h33, KILL_W'(33), 3'd0, 2'b00);
    bus.out_ready = 1'b1;
    bus.flush     = 1'b1;
    step();
    bus.flush = 1'b0;
    idle(3);

    // Asynchronous reset mid-cycle while full.
    bus.out_ready = 1'b0;
    offer(32'h44, KILL_W'(44), 3'd0, 2'b00);
    offer(32'h55, KILL_W'(55), 3'd0, 2'b00);
    idle(1);
    #2;
    reset = 1'b0;
    #1;
    chk("rst_out_valid", 128'(bus.out_valid),    128'(0));
    chk("rst_in_ready",  128'(bus.in_ready),     128'(1));
    chk("rst_occupancy", 128'(bus.occupancy),    128'(0));
    chk("rst_out_keep",  128'(bus.out_keep),     128'(0));
    chk("rst_out_kill",  128'(bus.out_kill),     128'(KILL_NOP));
    chk("rst_out_code",  128'(bus.out_exp_code), 128'(0));
    @(negedge clk);
    #2;
    reset = 1'b1;
    step();
    bus.out_ready = 1'b1;
    offer(32'h66, KILL_W'(66), 3'd2, 2'b00);
    idle(3);

    // Random traffic.
    for (int n = 0; n < 600; n++) begin
      bus.in_valid    = ($urandom_range(0, 99) < 70);
      bus.out_ready   = ($urandom_range(0, 99) < 60);
      bus.flush       = ($urandom_range(0, 99) < 3);
      bus.in_keep     = KEEP_W'($urandom());
      bus.in_kill     = KILL_W'({$urandom(), $urandom(), $urandom()});
      bus.in_exp_code = EXP_W'($urandom_range(0, 7));
      bus.exp_req     = ($urandom_range(0, 99) < 25) ? N_EXP'($urandom()) : '0;
      step();
    end
    bus.flush     = 1'b0;
    bus.out_ready = 1'b1;
    idle(5);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
